// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register file and its read ports.
package regfile_pkg;

    localparam int unsigned RDATA_WIDTH = 32;
    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned REG_DEPTH   = 32;

    localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;
    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// One operand read port: storage mux, same-cycle writeback bypass and
// pending-writer hazard flag. Purely combinational.
//   rst_n   : active-low reset, forces rdata to zero and busy low
//   re      : read enable
//   raddr   : read index
//   we/waddr/wdata : writeback presented this cycle (bypass source)
//   regs    : flattened register storage
//   pending : per-register in-flight writer marks
//   rdata   : read data
//   busy    : operand has an unresolved in-flight writer
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RDATA_WIDTH,
    parameter int unsigned ADDR_W = RADDR_WIDTH,
    parameter int unsigned DEPTH  = REG_DEPTH
) (
    input  logic                          rst_n,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             raddr,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              pending,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy
);

    logic active;
    logic wr_hit;

    assign active = rst_n && re && (raddr != ADDR_W'(ZERO_REG));
    assign wr_hit = (we == WRITE_ENABLE) && (waddr == raddr);

    // Read mux with bypass; a writeback this cycle also resolves the hazard.
    always_comb begin
        rdata = '0;
        busy  = 1'b0;
        if (active) begin
            rdata = wr_hit ? wdata : regs[raddr];
            busy  = pending[raddr] && !wr_hit;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural integer register file with pending-write scoreboard.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   we_i/waddr_i/wdata_i  : writeback stream
//   re1_i/raddr1_i/rdata1_o, re2_i/raddr2_i/rdata2_o : operand reads (comb)
//   issue_we_i/issue_waddr_i : decode marks a destination as in flight
//   flush_i               : drop all pending marks
//   busy1_o/busy2_o       : operand has an in-flight writer (comb)
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RDATA_WIDTH,
    parameter int unsigned ADDR_W = RADDR_WIDTH,
    parameter int unsigned DEPTH  = REG_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              issue_we_i,
    input  logic [ADDR_W-1:0] issue_waddr_i,
    input  logic              flush_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pending;
    logic [DEPTH-1:0]             wr_dec;
    logic [DEPTH-1:0]             iss_dec;

    // One-hot decode of writeback and issue targets; index 0 never selected.
    always_comb begin
        wr_dec  = '0;
        iss_dec = '0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            wr_dec[k]  = (we_i == WRITE_ENABLE) && (waddr_i == ADDR_W'(k));
            iss_dec[k] = issue_we_i && (issue_waddr_i == ADDR_W'(k));
        end
    end

    // Storage and scoreboard; issue beats a same-cycle writeback (newer writer).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            regs[0]    <= '0;
            pending[0] <= 1'b0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (wr_dec[k]) begin
                    regs[k] <= wdata_i;
                end
                if (flush_i) begin
                    pending[k] <= 1'b0;
                end else if (iss_dec[k]) begin
                    pending[k] <= 1'b1;
                end else if (wr_dec[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd_port1 (
        .rst_n   (rst_i),
        .re      (re1_i),
        .raddr   (raddr1_i),
        .we      (we_i),
        .waddr   (waddr_i),
        .wdata   (wdata_i),
        .regs    (regs),
        .pending (pending),
        .rdata   (rdata1_o),
        .busy    (busy1_o)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd_port2 (
        .rst_n   (rst_i),
        .re      (re2_i),
        .raddr   (raddr2_i),
        .we      (we_i),
        .waddr   (waddr_i),
        .wdata   (wdata_i),
        .regs    (regs),
        .pending (pending),
        .rdata   (rdata2_o),
        .busy    (busy2_o)
    );

endmodule
